adc_master: RTL and testbench

- Transmit end of the 4-bit nibble link consumed by the oven ADC slave.
- Snapshots the display digit, current temperature, set temperature and set time, then serialises them as a fixed 7-nibble frame.
- Each nibble is presented on `data` and qualified by a rising edge of `adc_int`.
- Sits in the sensor/ADC controller domain; `adc_int` and `data` drive the slave directly.

---
 rtl/adc_master_pkg.sv | 34 +++
 rtl/adc_nibble_mux.sv | 24 ++
 rtl/adc_master.sv | 171 +++++++++++++++++
 tb/tb_adc_master.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_master_pkg.sv
// Shared definitions for the oven ADC nibble link (master and slave agree on nibble order).
package adc_master_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    STROBE = 3'd2,
    HOLD   = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam int FRAME_NIBBLES = 7;
  localparam int SNAP_W        = 28;

  localparam logic [2:0] NIB_DIGIT_LO = 3'd0;
  localparam logic [2:0] NIB_DIGIT_HI = 3'd1;
  localparam logic [2:0] NIB_CUR_LO   = 3'd2;
  localparam logic [2:0] NIB_CUR_HI   = 3'd3;
  localparam logic [2:0] NIB_SET_LO   = 3'd4;
  localparam logic [2:0] NIB_SET_HI   = 3'd5;
  localparam logic [2:0] NIB_SET_TIME = 3'd6;
  localparam logic [2:0] NIB_LAST     = NIB_SET_TIME;

  // Snapshot layout: nibble i lives at bits [4i+3:4i].
  function automatic logic [SNAP_W-1:0] pack_snapshot(
    input logic [7:0] digit,
    input logic [7:0] cur_temp,
    input logic [7:0] tgt_temp,
    input logic [3:0] tgt_time
  );
    return {tgt_time, tgt_temp, cur_temp, digit};
  endfunction

endpackage

// File: rtl/adc_nibble_mux.sv
// Combinational nibble selector over the 28-bit frame snapshot; index 7 yields 0.
import adc_master_pkg::*;

module adc_nibble_mux (
  input  logic [SNAP_W-1:0] snap_i,
  input  logic [2:0]        idx_i,
  output logic [3:0]        nib_o
);

  always_comb begin
    nib_o = 4'h0;
    case (idx_i)
      NIB_DIGIT_LO: nib_o = snap_i[3:0];
      NIB_DIGIT_HI: nib_o = snap_i[7:4];
      NIB_CUR_LO:   nib_o = snap_i[11:8];
      NIB_CUR_HI:   nib_o = snap_i[15:12];
      NIB_SET_LO:   nib_o = snap_i[19:16];
      NIB_SET_HI:   nib_o = snap_i[23:20];
      NIB_SET_TIME: nib_o = snap_i[27:24];
      default:      nib_o = 4'h0;
    endcase
  end

endmodule

// File: rtl/adc_master.sv
// Transmit end of the oven ADC nibble link: snapshots payload, sends 7 strobed nibbles.
// Optional periodic self-triggering is enabled with `define ADC_MASTER_AUTO_EN.
import adc_master_pkg::*;

module adc_master #(
  parameter int SETUP_CYC = 2,
  parameter int HIGH_CYC  = 2,
  parameter int HOLD_CYC  = 2
`ifdef ADC_MASTER_AUTO_EN
  , parameter int AUTO_PERIOD = 1000000
`endif
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       send,
  input  logic [7:0] digit_adc,
  input  logic [7:0] current_temp,
  input  logic [7:0] set_temp,
  input  logic [3:0] set_time,
  output logic       adc_int,
  output logic [3:0] data,
  output logic       busy,
  output logic       done
);

  localparam int MAX_CYC = (SETUP_CYC > HIGH_CYC) ?
                           ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC) :
                           ((HIGH_CYC > HOLD_CYC) ? HIGH_CYC : HOLD_CYC);
  localparam int CW = $clog2(MAX_CYC + 1);
  localparam logic [CW-1:0] SETUP_LAST = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] HIGH_LAST  = CW'(HIGH_CYC - 1);
  localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD_CYC - 1);

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [2:0]          idx_q, idx_d;
  logic [SNAP_W-1:0]   snap_q, snap_d;
  logic                adc_int_q, adc_int_d;
  logic [3:0]          data_q, data_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [3:0]          nib;
  logic                req;

`ifdef ADC_MASTER_AUTO_EN
  localparam int PW = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;
  localparam logic [PW-1:0] PER_LAST = PW'(AUTO_PERIOD - 1);

  logic [PW-1:0] per_q, per_d;
  logic          auto_tick;

  // Free-running period counter; a tick landing while busy is simply lost.
  always_comb begin
    auto_tick = (per_q == PER_LAST);
    per_d     = auto_tick ? '0 : per_q + PW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) per_q <= '0;
    else        per_q <= per_d;
  end

  assign req = send | auto_tick;
`else
  assign req = send;
`endif

  // Looks ahead at the next snapshot/index so data is registered on SETUP entry.
  adc_nibble_mux u_mux (
    .snap_i (snap_d),
    .idx_i  (idx_d),
    .nib_o  (nib)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    snap_d    = snap_q;
    adc_int_d = 1'b0;
    data_d    = data_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (req) begin
          snap_d  = pack_snapshot(digit_adc, current_temp, set_temp, set_time);
          idx_d   = 3'd0;
          cnt_d   = '0;
          state_d = SETUP;
          data_d  = nib;
          busy_d  = 1'b1;
        end
      end
      SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          cnt_d     = '0;
          state_d   = STROBE;
          adc_int_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      STROBE: begin
        adc_int_d = 1'b1;
        if (cnt_q == HIGH_LAST) begin
          cnt_d     = '0;
          state_d   = HOLD;
          adc_int_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          cnt_d = '0;
          if (idx_q == NIB_LAST) begin
            state_d = DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            data_d  = 4'h0;
          end else begin
            idx_d   = idx_q + 3'd1;
            state_d = SETUP;
            data_d  = nib;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        data_d  = 4'h0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= 3'd0;
      snap_q    <= '0;
      adc_int_q <= 1'b0;
      data_q    <= 4'h0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      snap_q    <= snap_d;
      adc_int_q <= adc_int_d;
      data_q    <= data_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign adc_int = adc_int_q;
  assign data    = data_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_adc_master.sv
// Self-checking bench for adc_master: default timing instance plus a 1/1/1 timing corner instance.
module tb_adc_master;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       send;
  logic [7:0] digit_adc, current_temp, set_temp;
  logic [3:0] set_time;

  logic       adc_int0, busy0, done0;
  logic [3:0] data0;
  logic       adc_int1, busy1, done1;
  logic [3:0] data1;

  int total = 0;
  int bad   = 0;

  // Observation results of the most recent frame
  logic [3:0] capNib[$];
  int         riseCyc[$];
  int         doneCyc[$];
  int         stableErr;
  int         busyCnt;
  logic       busyEnd;

  always #5 clk = ~clk;

  adc_master dut0 (
    .clk(clk), .rst_n(rst_n), .send(send),
    .digit_adc(digit_adc), .current_temp(current_temp),
    .set_temp(set_temp), .set_time(set_time),
    .adc_int(adc_int0), .data(data0), .busy(busy0), .done(done0)
  );

  adc_master #(.SETUP_CYC(1), .HIGH_CYC(1), .HOLD_CYC(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .send(send),
    .digit_adc(digit_adc), .current_temp(current_temp),
    .set_temp(set_temp), .set_time(set_time),
    .adc_int(adc_int1), .data(data1), .busy(busy1), .done(done1)
  );

  // Reference model: nibble k of a frame, taken straight from the link's byte order.
  function automatic logic [3:0] exp_nib(input int k, input logic [7:0] d, input logic [7:0] c,
                                         input logic [7:0] t, input logic [3:0] tm);
    logic [3:0] n [7];
    n[0] = d[3:0]; n[1] = d[7:4];
    n[2] = c[3:0]; n[3] = c[7:4];
    n[4] = t[3:0]; n[5] = t[7:4];
    n[6] = tm;
    return n[k];
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Pulse send for one edge; on return we sit in cycle 1 of the accepted frame.
  task automatic start_frame(input logic [7:0] d, input logic [7:0] c,
                             input logic [7:0] t, input logic [3:0] tm);
    digit_adc = d; current_temp = c; set_temp = t; set_time = tm;
    send = 1'b1;
    tick();
    send = 1'b0;
  endtask

  // Watches one instance cycle by cycle, recording strobe captures, done pulses and data stability.
  task automatic observe(input bit corner, input int budget, input int changeCyc,
                         input int sendCyc, input bit sendAtDone);
    logic a, pa, dn, b;
    logic [3:0] dv, pd;
    int holdLeft;
    int holdCycles;
    capNib.delete(); riseCyc.delete(); doneCyc.delete();
    stableErr = 0; busyCnt = 0;
    pa = 1'b0; pd = 4'h0; holdLeft = 0;
    holdCycles = corner ? 1 : 2;
    for (int n = 1; n <= budget; n++) begin
      a  = corner ? adc_int1 : adc_int0;
      dv = corner ? data1 : data0;
      dn = corner ? done1 : done0;
      b  = corner ? busy1 : busy0;
      if ((a || pa || holdLeft > 0) && dv !== pd) stableErr++;
      if (a && !pa) begin
        capNib.push_back(dv);
        riseCyc.push_back(n);
      end
      if (dn) doneCyc.push_back(n);
      if (b) busyCnt++;
      if (pa && !a) holdLeft = holdCycles - 1;
      else if (holdLeft > 0) holdLeft--;
      pa = a; pd = dv;
      if (n == changeCyc) current_temp = 8'hFF;
      send = (n == sendCyc) || (sendAtDone && dn);
      tick();
    end
    send = 1'b0;
    busyEnd = corner ? busy1 : busy0;
  endtask

  task automatic wait_idle;
    int n;
    n = 0;
    while ((busy0 || busy1) && n < 100) begin
      tick();
      n++;
    end
    total++;
    if (busy0 || busy1) begin
      bad++;
      $display("[TB] FAIL wait_idle: busy0=%0b busy1=%0b still high, required 0 within 100 cycles", busy0, busy1);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; send = 1'b0;
    digit_adc = 8'($urandom); current_temp = 8'($urandom);
    set_temp = 8'($urandom); set_time = 4'($urandom);
    tick(); tick();
    total++; if (adc_int0 !== 1'b0) begin bad++; $display("[TB] FAIL reset_adc_int: got %0b need 0", adc_int0); end
    total++; if (data0 !== 4'h0) begin bad++; $display("[TB] FAIL reset_data: got %h need 0", data0); end
    total++; if (busy0 !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy: got %0b need 0", busy0); end
    total++; if (done0 !== 1'b0) begin bad++; $display("[TB] FAIL reset_done: got %0b need 0", done0); end
    total++; if ({adc_int1, data1, busy1, done1} !== 7'h0) begin bad++; $display("[TB] FAIL reset_corner: got %h need 0", {adc_int1, data1, busy1, done1}); end
    rst_n = 1'b1;
    tick();
  endtask

  // Full-frame checks for the default-timing instance against payload d/c/t/tm.
  task automatic test_frame_default(input string tag, input logic [7:0] d, input logic [7:0] c,
                                    input logic [7:0] t, input logic [3:0] tm, input int changeCyc);
    start_frame(d, c, t, tm);
    observe(1'b0, 50, changeCyc, -1, 1'b0);
    total++;
    if (capNib.size() !== 7) begin bad++; $display("[TB] FAIL %s_strobes: got %0d need 7", tag, capNib.size()); end
    for (int k = 0; k < 7 && k < capNib.size(); k++) begin
      total++;
      if (capNib[k] !== exp_nib(k, d, c, t, tm)) begin
        bad++; $display("[TB] FAIL %s_nib%0d: got %h need %h", tag, k, capNib[k], exp_nib(k, d, c, t, tm));
      end
      total++;
      if (riseCyc[k] !== 3 + 6 * k) begin
        bad++; $display("[TB] FAIL %s_rise%0d: got cycle %0d need %0d", tag, k, riseCyc[k], 3 + 6 * k);
      end
    end
    total++;
    if (doneCyc.size() !== 1) begin bad++; $display("[TB] FAIL %s_done_count: got %0d need 1", tag, doneCyc.size()); end
    else begin
      total++;
      if (doneCyc[0] !== 43) begin bad++; $display("[TB] FAIL %s_done_cycle: got %0d need 43", tag, doneCyc[0]); end
    end
    total++; if (busyCnt !== 42) begin bad++; $display("[TB] FAIL %s_busy_cycles: got %0d need 42", tag, busyCnt); end
    total++; if (busyEnd !== 1'b0) begin bad++; $display("[TB] FAIL %s_busy_after: got %0b need 0", tag, busyEnd); end
    total++; if (stableErr !== 0) begin bad++; $display("[TB] FAIL %s_stability: got %0d violations need 0", tag, stableErr); end
  endtask

  task automatic test_basic_frame;
    test_frame_default("basic", 8'hA5, 8'h3C, 8'hB4, 4'h9, -1);
  endtask

  task automatic test_random_frames;
    for (int r = 0; r < 4; r++)
      test_frame_default("random", 8'($urandom), 8'($urandom), 8'($urandom), 4'($urandom), -1);
  endtask

  task automatic test_input_change;
    test_frame_default("inchange", 8'($urandom), 8'h3C, 8'($urandom), 4'($urandom), 4);
  endtask

  task automatic test_send_while_busy;
    logic [7:0] d, c, t;
    logic [3:0] tm;
    d = 8'($urandom); c = 8'($urandom); t = 8'($urandom); tm = 4'($urandom);
    wait_idle();
    start_frame(d, c, t, tm);
    observe(1'b0, 60, -1, 10, 1'b1);
    total++; if (capNib.size() !== 7) begin bad++; $display("[TB] FAIL busy_send_strobes: got %0d need 7", capNib.size()); end
    total++; if (doneCyc.size() !== 1) begin bad++; $display("[TB] FAIL busy_send_done_count: got %0d need 1", doneCyc.size()); end
    total++; if (busyEnd !== 1'b0) begin bad++; $display("[TB] FAIL busy_send_busy_after: got %0b need 0", busyEnd); end
    if (capNib.size() == 7) begin
      total++;
      if (capNib[6] !== tm) begin bad++; $display("[TB] FAIL busy_send_last_nib: got %h need %h", capNib[6], tm); end
    end
  endtask

  // Earliest legal restart: send in the cycle right after done.
  task automatic test_back_to_back;
    logic [7:0] d, c, t;
    logic [3:0] tm;
    wait_idle();
    start_frame(8'($urandom), 8'($urandom), 8'($urandom), 4'($urandom));
    observe(1'b0, 43, -1, -1, 1'b0);
    total++;
    if (doneCyc.size() !== 1 || doneCyc[0] !== 43) begin
      bad++; $display("[TB] FAIL b2b_first_done: got %0d pulses need 1 at cycle 43", doneCyc.size());
    end
    d = 8'($urandom); c = 8'($urandom); t = 8'($urandom); tm = 4'($urandom);
    start_frame(d, c, t, tm);
    observe(1'b0, 45, -1, -1, 1'b0);
    total++; if (capNib.size() !== 7) begin bad++; $display("[TB] FAIL b2b_strobes: got %0d need 7", capNib.size()); end
    for (int k = 0; k < 7 && k < capNib.size(); k++) begin
      total++;
      if (capNib[k] !== exp_nib(k, d, c, t, tm)) begin
        bad++; $display("[TB] FAIL b2b_nib%0d: got %h need %h", k, capNib[k], exp_nib(k, d, c, t, tm));
      end
    end
    total++;
    if (riseCyc.size() == 0 || riseCyc[0] !== 3) begin bad++; $display("[TB] FAIL b2b_first_rise: got %0d rises need first at cycle 3", riseCyc.size()); end
  endtask

  task automatic test_reset_mid_frame;
    logic a, pa;
    int rises;
    bit hit;
    wait_idle();
    start_frame(8'($urandom), 8'($urandom), 8'($urandom), 4'($urandom));
    pa = 1'b0; rises = 0; hit = 1'b0;
    for (int n = 1; n <= 40 && !hit; n++) begin
      a = adc_int0;
      if (a && !pa) rises++;
      pa = a;
      if (rises == 4) begin
        hit = 1'b1;
        rst_n = 1'b0;
        tick();
        total++; if (adc_int0 !== 1'b0) begin bad++; $display("[TB] FAIL midreset_adc_int: got %0b need 0", adc_int0); end
        total++; if (data0 !== 4'h0) begin bad++; $display("[TB] FAIL midreset_data: got %h need 0", data0); end
        total++; if (busy0 !== 1'b0) begin bad++; $display("[TB] FAIL midreset_busy: got %0b need 0", busy0); end
        rst_n = 1'b1;
      end
      tick();
    end
    total++;
    if (!hit) begin bad++; $display("[TB] FAIL midreset_reach_strobe4: got %0d rises need 4 within 40 cycles", rises); end
    test_frame_default("postreset", 8'($urandom), 8'($urandom), 8'($urandom), 4'($urandom), -1);
  endtask

  task automatic test_timing_corner;
    logic [7:0] d, c, t;
    logic [3:0] tm;
    wait_idle();
    d = 8'($urandom); c = 8'($urandom); t = 8'($urandom); tm = 4'($urandom);
    start_frame(d, c, t, tm);
    observe(1'b1, 30, -1, -1, 1'b0);
    total++; if (capNib.size() !== 7) begin bad++; $display("[TB] FAIL corner_strobes: got %0d need 7", capNib.size()); end
    for (int k = 0; k < 7 && k < capNib.size(); k++) begin
      total++;
      if (capNib[k] !== exp_nib(k, d, c, t, tm)) begin
        bad++; $display("[TB] FAIL corner_nib%0d: got %h need %h", k, capNib[k], exp_nib(k, d, c, t, tm));
      end
      total++;
      if (riseCyc[k] !== 2 + 3 * k) begin
        bad++; $display("[TB] FAIL corner_rise%0d: got cycle %0d need %0d", k, riseCyc[k], 2 + 3 * k);
      end
    end
    total++;
    if (doneCyc.size() !== 1 || doneCyc[0] !== 22) begin
      bad++; $display("[TB] FAIL corner_done: got %0d pulses need 1 at cycle 22", doneCyc.size());
    end
    total++; if (busyCnt !== 21) begin bad++; $display("[TB] FAIL corner_busy_cycles: got %0d need 21", busyCnt); end
    total++; if (stableErr !== 0) begin bad++; $display("[TB] FAIL corner_stability: got %0d violations need 0", stableErr); end
  endtask

  initial begin
    rst_n = 1'b0; send = 1'b0;
    digit_adc = 8'h0; current_temp = 8'h0; set_temp = 8'h0; set_time = 4'h0;
    test_reset();
    test_basic_frame();
    test_random_frames();
    test_input_change();
    test_send_while_busy();
    test_back_to_back();
    test_reset_mid_frame();
    test_timing_corner();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
